// File: rtl/axis_layer_router.sv
// Header-routed AXI-Stream switch between a DRAM-side stream pair and N_ENG layer engines.
// Each command gets one engine, a bounded wait for its result, and a bad-selector drain path.
module axis_layer_router #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned KEEP_W      = DATA_W / 8,
    parameter int unsigned N_ENG       = 4,
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    S_AXIS_ACLK,
    input  logic                    S_AXIS_ARESETN,
    input  logic [DATA_W-1:0]       S_AXIS_TDATA,
    input  logic [KEEP_W-1:0]       S_AXIS_TKEEP,
    input  logic                    S_AXIS_TLAST,
    input  logic                    S_AXIS_TVALID,
    output logic                    S_AXIS_TREADY,
    output logic [DATA_W-1:0]       M_AXIS_TDATA,
    output logic [KEEP_W-1:0]       M_AXIS_TKEEP,
    output logic                    M_AXIS_TLAST,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [N_ENG*DATA_W-1:0] ENG_S_TDATA,
    output logic [N_ENG*KEEP_W-1:0] ENG_S_TKEEP,
    output logic [N_ENG-1:0]        ENG_S_TLAST,
    output logic [N_ENG-1:0]        ENG_S_TVALID,
    input  logic [N_ENG-1:0]        ENG_S_TREADY,
    input  logic [N_ENG*DATA_W-1:0] ENG_M_TDATA,
    input  logic [N_ENG*KEEP_W-1:0] ENG_M_TKEEP,
    input  logic [N_ENG-1:0]        ENG_M_TLAST,
    input  logic [N_ENG-1:0]        ENG_M_TVALID,
    output logic [N_ENG-1:0]        ENG_M_TREADY,
    output logic [N_ENG-1:0]        ENG_ARESETN,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    err_bad_sel,
    output logic                    err_timeout,
    output logic [15:0]             pkt_count
);

    localparam int unsigned TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TimerLast = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [SEL_W:0] NumEng = (SEL_W + 1)'(N_ENG);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               in_done_q, in_done_d;
    logic               out_done_q, out_done_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_ENG-1:0]   eng_rstn_q, eng_rstn_d;
    logic               err_bad_sel_q, err_bad_sel_d;
    logic               err_timeout_q, err_timeout_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic [N_ENG-1:0]   sel_onehot;
    logic               eng_s_tready_sel;
    logic               eng_m_tvalid_sel;
    logic               eng_m_tlast_sel;
    logic [DATA_W-1:0]  eng_m_tdata_sel;
    logic [KEEP_W-1:0]  eng_m_tkeep_sel;
    logic               in_hs, out_hs, timeout_fire;

    always_comb begin
        sel_onehot       = '0;
        eng_s_tready_sel = 1'b0;
        eng_m_tvalid_sel = 1'b0;
        eng_m_tlast_sel  = 1'b0;
        eng_m_tdata_sel  = '0;
        eng_m_tkeep_sel  = '0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_onehot[i]    = 1'b1;
                eng_s_tready_sel = ENG_S_TREADY[i];
                eng_m_tvalid_sel = ENG_M_TVALID[i];
                eng_m_tlast_sel  = ENG_M_TLAST[i];
                eng_m_tdata_sel  = ENG_M_TDATA[i*DATA_W +: DATA_W];
                eng_m_tkeep_sel  = ENG_M_TKEEP[i*KEEP_W +: KEEP_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        in_done_d     = in_done_q;
        out_done_d    = out_done_q;
        timer_d       = timer_q;
        eng_rstn_d    = eng_rstn_q;
        err_bad_sel_d = err_bad_sel_q;
        err_timeout_d = err_timeout_q;
        pkt_count_d   = pkt_count_q;
        S_AXIS_TREADY = 1'b0;
        M_AXIS_TVALID = 1'b0;
        ENG_S_TVALID  = '0;
        ENG_M_TREADY  = '0;
        in_hs         = 1'b0;
        out_hs        = 1'b0;
        timeout_fire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID && !S_AXIS_TLAST) begin
                    if ({1'b0, S_AXIS_TDATA[SEL_W-1:0]} >= NumEng) begin
                        err_bad_sel_d = 1'b1;
                        state_d       = StDrain;
                    end else begin
                        sel_d      = S_AXIS_TDATA[SEL_W-1:0];
                        in_done_d  = 1'b0;
                        out_done_d = 1'b0;
                        timer_d    = '0;
                        eng_rstn_d = N_ENG'(1) << S_AXIS_TDATA[SEL_W-1:0];
                        state_d    = StRun;
                    end
                end
            end
            StRun: begin
                // Timeout only decides on registered state so M_AXIS_TVALID never sees TREADY.
                timeout_fire = (TIMEOUT_CYC != 0) && in_done_q && !out_done_q &&
                               (timer_q == TimerLast);
                if (!in_done_q) begin
                    ENG_S_TVALID  = sel_onehot & {N_ENG{S_AXIS_TVALID}};
                    S_AXIS_TREADY = eng_s_tready_sel;
                    in_hs         = S_AXIS_TVALID && eng_s_tready_sel;
                end
                if (!out_done_q && !timeout_fire) begin
                    M_AXIS_TVALID = eng_m_tvalid_sel;
                    ENG_M_TREADY  = sel_onehot & {N_ENG{M_AXIS_TREADY}};
                    out_hs        = eng_m_tvalid_sel && M_AXIS_TREADY;
                end
                in_done_d  = in_done_q | (in_hs & S_AXIS_TLAST);
                out_done_d = out_done_q | (out_hs & eng_m_tlast_sel);
                if (out_hs) begin
                    timer_d = '0;
                end else if (in_done_q && (TIMEOUT_CYC != 0)) begin
                    timer_d = timer_q + 1'b1;
                end
                if (timeout_fire) begin
                    err_timeout_d = 1'b1;
                    eng_rstn_d    = '0;
                    state_d       = StIdle;
                end else if (in_done_d && out_done_d) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    eng_rstn_d  = '0;
                    state_d     = StIdle;
                end
            end
            StDrain: begin
                S_AXIS_TREADY = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q       <= StIdle;
            sel_q         <= '0;
            in_done_q     <= 1'b0;
            out_done_q    <= 1'b0;
            timer_q       <= '0;
            eng_rstn_q    <= '0;
            err_bad_sel_q <= 1'b0;
            err_timeout_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            in_done_q     <= in_done_d;
            out_done_q    <= out_done_d;
            timer_q       <= timer_d;
            eng_rstn_q    <= eng_rstn_d;
            err_bad_sel_q <= err_bad_sel_d;
            err_timeout_q <= err_timeout_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    // Payload is broadcast; only the selected engine gets TVALID.
    assign ENG_S_TDATA  = {N_ENG{S_AXIS_TDATA}};
    assign ENG_S_TKEEP  = {N_ENG{S_AXIS_TKEEP}};
    assign ENG_S_TLAST  = {N_ENG{S_AXIS_TLAST}};
    assign M_AXIS_TDATA = eng_m_tdata_sel;
    assign M_AXIS_TKEEP = eng_m_tkeep_sel;
    assign M_AXIS_TLAST = eng_m_tlast_sel;
    assign ENG_ARESETN  = eng_rstn_q;
    assign busy         = (state_q != StIdle);
    assign cur_sel      = sel_q;
    assign err_bad_sel  = err_bad_sel_q;
    assign err_timeout  = err_timeout_q;
    assign pkt_count    = pkt_count_q;

endmodule
